fix_tx_sched: RTL

FIX_TX_SCHED -- requirements
Module: fix_tx_sched

---
 rtl/fix_tx_sched.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/fix_tx_sched.sv
// rtl/fix_tx_sched.sv - two-requester FIX body scheduler that appends the "10=NNN<SOH>" checksum trailer
module fix_tx_sched #(
   parameter int DATA_WIDTH = 8,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] s0_data,
   input  logic                  s0_valid,
   input  logic                  s0_last,
   output logic                  s0_ready,
   input  logic [DATA_WIDTH-1:0] s1_data,
   input  logic                  s1_valid,
   input  logic                  s1_last,
   output logic                  s1_ready,
   output logic [DATA_WIDTH-1:0] m_data,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic                  m_last,
   output logic [1:0]            grant,
   output logic                  busy,
   output logic [CNT_WIDTH-1:0]  msg_count
);

   typedef enum logic [1:0] {IDLE, BODY, TRAIL} state_t;

   state_t               state_q, state_d;
   logic [1:0]           grant_q, grant_d;
   logic                 ptr_q, ptr_d;
   logic [7:0]           sum_q, sum_d;
   logic [2:0]           idx_q, idx_d;
   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

   logic [7:0] hund, rem, tens, units;
   logic [7:0] trail_byte;
   logic       body_last;

   // Decimal digits of the frozen checksum and the trailer byte at the current index
   always_comb begin
      hund  = sum_q / 8'd100;
      rem   = sum_q - hund * 8'd100;
      tens  = rem / 8'd10;
      units = rem - tens * 8'd10;
      case (idx_q)
         3'd0:    trail_byte = 8'h31;
         3'd1:    trail_byte = 8'h30;
         3'd2:    trail_byte = 8'h3D;
         3'd3:    trail_byte = 8'h30 + hund;
         3'd4:    trail_byte = 8'h30 + tens;
         3'd5:    trail_byte = 8'h30 + units;
         default: trail_byte = 8'h01;
      endcase
   end

   // Next-state, arbitration, pass-through and trailer emission
   always_comb begin
      state_d   = state_q;
      grant_d   = grant_q;
      ptr_d     = ptr_q;
      sum_d     = sum_q;
      idx_d     = idx_q;
      cnt_d     = cnt_q;
      m_data    = '0;
      m_valid   = 1'b0;
      m_last    = 1'b0;
      s0_ready  = 1'b0;
      s1_ready  = 1'b0;
      body_last = 1'b0;
      case (state_q)
         IDLE: begin
            if (s0_valid || s1_valid) begin
               state_d = BODY;
               // s0 wins when it is the only requester or when the pointer favours it
               if (s0_valid && (!s1_valid || !ptr_q)) grant_d = 2'b01;
               else                                   grant_d = 2'b10;
            end
         end
         BODY: begin
            if (grant_q[1]) begin
               m_data    = s1_data;
               m_valid   = s1_valid;
               s1_ready  = m_ready;
               body_last = s1_last;
            end else begin
               m_data    = s0_data;
               m_valid   = s0_valid;
               s0_ready  = m_ready;
               body_last = s0_last;
            end
            if (m_valid && m_ready) begin
               sum_d = sum_q + m_data;
               if (body_last) begin
                  state_d = TRAIL;
                  idx_d   = 3'd0;
               end
            end
         end
         TRAIL: begin
            m_valid = 1'b1;
            m_data  = trail_byte;
            m_last  = (idx_q == 3'd6);
            if (m_ready) begin
               if (idx_q == 3'd6) begin
                  state_d = IDLE;
                  grant_d = 2'b00;
                  sum_d   = 8'd0;
                  idx_d   = 3'd0;
                  cnt_d   = cnt_q + 1'b1;
                  // Hand priority to whichever requester was not just served
                  ptr_d   = grant_q[0];
               end else begin
                  idx_d = idx_q + 3'd1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State registers with asynchronous clear
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         grant_q <= 2'b00;
         ptr_q   <= 1'b0;
         sum_q   <= 8'd0;
         idx_q   <= 3'd0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         ptr_q   <= ptr_d;
         sum_q   <= sum_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
      end
   end

   assign grant     = grant_q;
   assign busy      = (state_q != IDLE);
   assign msg_count = cnt_q;

endmodule
